// File: rtl/perceptron_wupdate.sv
// Perceptron weight-update initiator.
// Walks every stored weight with a read / compute / write sequence and applies
// w[i] <= sat16(w[i] + ((re * x[i]) >>> FRAC)), where re = (lr * err) >>> FRAC
// is latched once per pass. All values are signed Q6.9.
module perceptron_wupdate #(
    parameter int N_W  = 64,
    parameter int FRAC = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] err,
    input  logic [15:0] lr,
    output logic        busy,
    output logic        done,
    output logic        sat,
    output logic        w_ena,
    output logic        w_wr_rd,
    output logic [6:0]  w_addr,
    output logic [15:0] w_wdata,
    input  logic [15:0] w_rdata,
    output logic        x_ena,
    output logic [6:0]  x_addr,
    input  logic [15:0] x_rdata
);

    localparam logic [6:0] LAST_IDX = 7'(N_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CALC,
        WR,
        DONE
    } state_t;

    state_t             state_q;
    logic [6:0]         idx_q;
    logic signed [15:0] re_q;
    logic               busy_q;
    logic               done_q;
    logic               sat_q;
    logic               w_ena_q;
    logic               w_wr_rd_q;
    logic [6:0]         w_addr_q;
    logic [15:0]        w_wdata_q;
    logic               x_ena_q;
    logic [6:0]         x_addr_q;

    logic signed [15:0] lrS;
    logic signed [15:0] errS;
    logic signed [15:0] xS;
    logic signed [15:0] wS;
    logic signed [31:0] prodRe;
    logic signed [31:0] prodD;
    logic signed [15:0] re_d;
    logic signed [15:0] delta;
    logic signed [16:0] sum17;
    logic signed [15:0] nw_d;
    logic               clamp_d;

    // Scaled error for the next pass and the saturated new weight for the current element
    always_comb begin
        lrS     = lr;
        errS    = err;
        xS      = x_rdata;
        wS      = w_rdata;
        prodRe  = lrS * errS;
        re_d    = 16'(prodRe >>> FRAC);
        prodD   = re_q * xS;
        delta   = 16'(prodD >>> FRAC);
        sum17   = {wS[15], wS} + {delta[15], delta};
        nw_d    = sum17[15:0];
        clamp_d = 1'b0;
        if (sum17[16:15] == 2'b01) begin
            nw_d    = 16'sh7FFF;
            clamp_d = 1'b1;
        end else if (sum17[16:15] == 2'b10) begin
            nw_d    = -16'sh8000;
            clamp_d = 1'b1;
        end
    end

    // Sequencer: state, element index and all registered memory-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            re_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            w_ena_q   <= 1'b0;
            w_wr_rd_q <= 1'b0;
            w_addr_q  <= '0;
            w_wdata_q <= '0;
            x_ena_q   <= 1'b0;
            x_addr_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            w_ena_q   <= 1'b0;
            w_wr_rd_q <= 1'b0;
            x_ena_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        re_q  <= re_d;
                        sat_q <= 1'b0;
                        idx_q <= '0;
                        if (err == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= RD;
                            busy_q   <= 1'b1;
                            w_ena_q  <= 1'b1;
                            w_addr_q <= '0;
                            x_ena_q  <= 1'b1;
                            x_addr_q <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD: begin
                    state_q <= CALC;
                end
                CALC: begin
                    state_q   <= WR;
                    w_wdata_q <= nw_d;
                    w_ena_q   <= 1'b1;
                    w_wr_rd_q <= 1'b1;
                    w_addr_q  <= idx_q;
                    if (clamp_d) begin
                        sat_q <= 1'b1;
                    end
                end
                WR: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= RD;
                        idx_q    <= idx_q + 7'd1;
                        w_ena_q  <= 1'b1;
                        w_addr_q <= idx_q + 7'd1;
                        x_ena_q  <= 1'b1;
                        x_addr_q <= idx_q + 7'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sat     = sat_q;
    assign w_ena   = w_ena_q;
    assign w_wr_rd = w_wr_rd_q;
    assign w_addr  = w_addr_q;
    assign w_wdata = w_wdata_q;
    assign x_ena   = x_ena_q;
    assign x_addr  = x_addr_q;

endmodule

// File: tb/tb_perceptron_wupdate.sv
// Self-checking bench for perceptron_wupdate with four weights.
// Holds behavioural weight and input memories with a one-cycle registered read.
module tb_perceptron_wupdate;

   localparam int NW = 4;
   localparam int LIMIT = 200;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] err;
   logic [15:0] lr;
   logic        busy;
   logic        done;
   logic        sat;
   logic        w_ena;
   logic        w_wr_rd;
   logic [6:0]  w_addr;
   logic [15:0] w_wdata;
   logic [15:0] w_rdata;
   logic        x_ena;
   logic [6:0]  x_addr;
   logic [15:0] x_rdata;

   logic signed [15:0] wMem [NW];
   logic signed [15:0] xMem [NW];
   logic               loadEn;
   logic [1:0]         loadAddr;
   logic [15:0]        loadW;
   logic [15:0]        loadX;
   int                 wrCount;
   int                 rdCount;
   int                 xCount;
   int                 badW;
   int                 badX;

   int checks;
   int failures;
   int doneCyc;
   int busyCnt;
   int rd0;
   int wr0;
   int x0;

   typedef struct packed {
      logic [3:0][15:0] wInit;
      logic [3:0][15:0] xInit;
      logic [15:0]      lrV;
      logic [15:0]      errV;
      logic [3:0][15:0] wExp;
      logic             satExp;
   } vec_t;

   vec_t vecs [6];

   perceptron_wupdate #(.N_W(NW), .FRAC(9)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .err     (err),
      .lr      (lr),
      .busy    (busy),
      .done    (done),
      .sat     (sat),
      .w_ena   (w_ena),
      .w_wr_rd (w_wr_rd),
      .w_addr  (w_addr),
      .w_wdata (w_wdata),
      .w_rdata (w_rdata),
      .x_ena   (x_ena),
      .x_addr  (x_addr),
      .x_rdata (x_rdata)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Weight and input memories: backdoor load port plus the DUT-facing registered ports
   always @(posedge clk) begin
      if (loadEn) begin
         wMem[loadAddr] <= loadW;
         xMem[loadAddr] <= loadX;
      end
      if (w_ena) begin
         if (w_addr >= 7'(NW)) begin
            badW <= badW + 1;
         end else if (w_wr_rd) begin
            wMem[w_addr[1:0]] <= w_wdata;
            wrCount <= wrCount + 1;
         end else begin
            w_rdata <= wMem[w_addr[1:0]];
            rdCount <= rdCount + 1;
         end
      end
      if (x_ena) begin
         if (x_addr >= 7'(NW)) begin
            badX <= badX + 1;
         end else begin
            x_rdata <= xMem[x_addr[1:0]];
            xCount <= xCount + 1;
         end
      end
   end

   function automatic vec_t mkVec(input int w0, w1, w2, w3, x0v, x1, x2, x3,
                                  input int lrV, errV, e0, e1, e2, e3, input int satV);
      vec_t v;
      v.wInit  = {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
      v.xInit  = {16'(x3), 16'(x2), 16'(x1), 16'(x0v)};
      v.lrV    = 16'(lrV);
      v.errV   = 16'(errV);
      v.wExp   = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
      v.satExp = satV[0];
      return v;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic loadMems(input logic [3:0][15:0] wv, input logic [3:0][15:0] xv);
      for (int i = 0; i < NW; i++) begin
         loadEn   = 1'b1;
         loadAddr = 2'(i);
         loadW    = wv[i];
         loadX    = xv[i];
         @(posedge clk);
         #1;
      end
      loadEn = 1'b0;
   endtask

   // Raises start so that the next edge is edge 0; returns one tick after it
   task automatic applyStimulus(input logic [15:0] lrV, input logic [15:0] errV);
      lr    = lrV;
      err   = errV;
      start = 1'b1;
      rd0   = rdCount;
      wr0   = wrCount;
      x0    = xCount;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("satClearedOnStart", int'(sat), 0);
   endtask

   // Follows the pass from cycle 1 until done or the cycle budget; optional start poke
   task automatic waitDone(input int pokeCyc);
      int cyc;
      cyc     = 1;
      busyCnt = busy ? 1 : 0;
      while (!done && cyc < LIMIT) begin
         if (cyc == pokeCyc) begin
            start = 1'b1;
            err   = 16'h7FFF;
            lr    = 16'h7FFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (busy) busyCnt++;
      end
      start   = 1'b0;
      doneCyc = cyc;
      if (!done) begin
         checkOutput("doneTimeout", 0, 1);
      end
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput(name, int'({busy, done, sat, w_ena, w_wr_rd, x_ena}), 0);
      checkOutput({name, "_addr"}, int'({w_addr, x_addr}), 0);
      checkOutput({name, "_wdata"}, int'(w_wdata), 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      wrCount  = 0;
      rdCount  = 0;
      xCount   = 0;
      badW     = 0;
      badX     = 0;
      w_rdata  = '0;
      x_rdata  = '0;
      loadEn   = 1'b0;
      loadAddr = '0;
      loadW    = '0;
      loadX    = '0;
      start    = 1'b0;
      err      = '0;
      lr       = '0;
      rst_n    = 1'b0;

      vecs[0] = mkVec(128, 0, -128, 512,  512, 512, 512, 0,  256, 512,  384, 256, 128, 512, 0);
      vecs[1] = mkVec(32767, 0, 0, 0,  512, 0, 0, 0,  256, 512,  32767, 0, 0, 0, 1);
      vecs[2] = mkVec(-32700, 0, 0, 0,  512, 0, 0, 0,  256, -512,  -32768, 0, 0, 0, 1);
      vecs[3] = mkVec(100, -5, 0, 7,  1, 1, 1, 1,  1, 512,  100, -5, 0, 7, 0);
      vecs[4] = mkVec(100, -5, 0, 7,  1, 1, 1, 1,  -1, 512,  99, -6, -1, 6, 0);
      vecs[5] = mkVec(1000, 1000, 1000, 1000,  1024, -512, 100, 0,  512, -256,  488, 1256, 950, 1000, 0);

      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("resetState");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         loadMems(vecs[v].wInit, vecs[v].xInit);
         applyStimulus(vecs[v].lrV, vecs[v].errV);
         waitDone((v == 0) ? 5 : 0);
         checkOutput($sformatf("v%0d_doneCycle", v), doneCyc, 3 * NW + 1);
         checkOutput($sformatf("v%0d_busyCycles", v), busyCnt, 3 * NW);
         checkOutput($sformatf("v%0d_sat", v), int'(sat), int'(vecs[v].satExp));
         checkOutput($sformatf("v%0d_reads", v), rdCount - rd0, NW);
         checkOutput($sformatf("v%0d_writes", v), wrCount - wr0, NW);
         checkOutput($sformatf("v%0d_xReads", v), xCount - x0, NW);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_donePulse", v), int'(done), 0);
         for (int i = 0; i < NW; i++) begin
            checkOutput($sformatf("v%0d_w%0d", v, i), int'(wMem[i]),
                        int'($signed(vecs[v].wExp[i])));
         end
      end

      // err == 0: immediate done, no memory traffic
      loadMems({16'd4, 16'd3, 16'd2, 16'd1}, {16'd512, 16'd512, 16'd512, 16'd512});
      applyStimulus(16'd256, 16'd0);
      waitDone(0);
      checkOutput("err0_doneCycle", doneCyc, 1);
      checkOutput("err0_busyCycles", busyCnt, 0);
      checkOutput("err0_traffic", (rdCount - rd0) + (wrCount - wr0) + (xCount - x0), 0);
      checkOutput("err0_w0", int'(wMem[0]), 1);

      // Back-to-back: start held during the DONE cycle restarts at address 0
      loadMems('0, {16'd512, 16'd512, 16'd512, 16'd512});
      applyStimulus(16'd256, 16'd512);
      waitDone(0);
      checkOutput("b2b_firstDone", doneCyc, 3 * NW + 1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_restartRead", int'({busy, w_ena, w_wr_rd, x_ena}), int'(4'b1101));
      checkOutput("b2b_restartAddr", int'({w_addr, x_addr}), 0);
      waitDone(0);
      checkOutput("b2b_secondDone", doneCyc, 3 * NW + 1);
      for (int i = 0; i < NW; i++) begin
         checkOutput($sformatf("b2b_w%0d", i), int'(wMem[i]), 512);
      end

      // Reset during the CALC cycle of element 2
      loadMems({16'd4000, 16'd3000, 16'd2000, 16'd1000}, {16'd512, 16'd512, 16'd512, 16'd512});
      applyStimulus(16'd256, 16'd512);
      for (int c = 1; c < 8; c++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkResetOutputs("midReset");
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midReset_writes", wrCount - wr0, 2);
      checkOutput("midReset_w0", int'(wMem[0]), 1256);
      checkOutput("midReset_w1", int'(wMem[1]), 2256);
      checkOutput("midReset_w2", int'(wMem[2]), 3000);
      checkOutput("midReset_w3", int'(wMem[3]), 4000);

      checkOutput("outOfRangeAccess", badW + badX, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/perceptron_wupdate.md
Name: perceptron_wupdate

Overview:
- Training-side initiator for the weight memory. Applies the perceptron rule w[i] <= sat16(w[i] + ((lr*err)>>>9 * x[i])>>>9) over all weights.
- Does read-modify-write through the weight memory's enable/wr_rd/addr port, which has a 1-cycle registered read.
- Reads the input vector from a read-only memory with the same 1-cycle read timing.
- All values are signed 16-bit Q6.9 (real value x 512), matching the stored weight format.

Parameters:
N_W, 64, number of weights updated per run (1..64); addresses 0..N_W-1.
FRAC, 9, fractional bits of the Q format (scale 512).

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  request one update pass; sampled only in IDLE or DONE
err  input  16  signed Q6.9 error (target - output); sampled with start
lr  input  16  signed Q6.9 learning rate; sampled with start
busy  output  1  high from the cycle after start is accepted until the last write cycle, inclusive
done  output  1  one-cycle pulse after the last write, or after an err==0 run
sat  output  1  sticky: some weight saturated this run; cleared when start is accepted
w_ena  output  1  weight memory enable
w_wr_rd  output  1  1 = write, 0 = read
w_addr  output  7  weight address, upper bit always 0
w_wdata  output  16  write data to weight memory
w_rdata  input  16  weight memory read data, valid the cycle after a read cycle
x_ena  output  1  input memory read enable
x_addr  output  7  input memory address
x_rdata  input  16  input memory read data, valid the cycle after x_ena

Behaviour:
Reset:
- rst_n=0 at a posedge puts the block in IDLE.
- Outputs after reset: busy=0, done=0, sat=0, w_ena=0, w_wr_rd=0, w_addr=0, w_wdata=0, x_ena=0, x_addr=0.
- Reset mid-run aborts immediately; no further memory access occurs. A weight already written stays written.

States: IDLE, RD, CALC, WR, DONE.
- IDLE/DONE with start=1:
  - Latch re = (lr*err)>>>FRAC. The product is 32-bit signed, the shift is arithmetic (floor), and the result is truncated to 16 bits.
  - Clear sat and set i=0.
  - Go to RD, or go to DONE if err==0 (no memory access in that case).
- IDLE/DONE with start=0: go to or stay in IDLE. DONE lasts exactly one cycle.
- RD: w_ena=1, w_wr_rd=0, w_addr=i, x_ena=1, x_addr=i. Next state CALC.
- CALC: all enables 0.
  - Compute d = (re*x_rdata)>>>FRAC, arithmetic shift.
  - Compute s = w_rdata + d with 17-bit sign extension.
  - Register nw = s clamped to [-32768, 32767]; set sat=1 if clamping occurred.
  - Next state WR.
- WR: w_ena=1, w_wr_rd=1, w_addr=i, w_wdata=nw, x_ena=0.
  - If i==N_W-1, go to DONE; otherwise i<=i+1 and go to RD.
- DONE: done=1, busy=0, all enables 0.

Timing and outputs:
- busy=1 in RD, CALC and WR only.
- Timing: start sampled at edge 0; element i occupies cycles 3i+1 (RD), 3i+2 (CALC) and 3i+3 (WR); done=1 in cycle 3*N_W+1.
- For N_W=64, a pass takes 192 busy cycles.
- start while busy is ignored, and err/lr changes while busy have no effect.
- w_ena is never asserted for an address >= N_W.
- w_wr_rd=1 only in WR.
- Outside RD/WR: w_addr and w_wdata hold their last values, and w_ena=0.

Test Plan:
1. Nominal update:
   - Stimulus: N_W=4, w={128,0,-128,512}, x={512,512,512,0}, lr=256 (0.5), err=512 (+1).
   - Required: re=256; final w={384,256,128,512}; done pulses at cycle 13; sat=0; exactly 4 reads and 4 writes at addresses 0..3.
2. Saturation, both signs:
   - Stimulus: w[0]=32767, x[0]=512, lr=256, err=512; then w[0]=-32700, err=-512.
   - Required: first run gives w[0]=32767 and sat=1; second run gives w[0]=-32768 and sat=1. sat is cleared at the start of each run.
3. Floor rounding:
   - Stimulus: lr=1, err=512 (re=1), x=1.
   - Required: d=0 and w unchanged.
   - Stimulus: lr=-1, err=512 (re=-1), x=1.
   - Required: d=-1 and w decremented by 1.
4. err=0: start -> no w_ena/x_ena ever asserted; done=1 in cycle 1; busy never high.
5. Start during busy and back-to-back:
   - Stimulus: pulse start at cycle 5 of a run.
   - Required: ignored; the run completes unchanged.
   - Stimulus: assert start in the DONE cycle.
   - Required: a new run begins next cycle (RD at address 0).
6. Reset mid-run:
   - Stimulus: rst_n=0 in the CALC cycle of element 2.
   - Required: next cycle all outputs at reset values; w[0..1] updated; w[2..N_W-1] untouched.
